// File: rtl/mfp_sonar_ranger_pkg.sv
// Shared types and constants for the ultrasonic ranger front end.
// State encoding, result codes and a counter-width helper.
package mfp_sonar_ranger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_HOLD
  } sonar_state_e;

  localparam logic [15:0] SONAR_TIMEOUT_CODE = 16'hFFFF;
  localparam logic [15:0] SONAR_CM_SAT       = 16'hFFFE;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mfp_sync2.sv
// Two-flop synchronizer for asynchronous pins (echo, buttons, switches).
// Latency: 2 clk. Backpressure: none.
module mfp_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mfp_sonar_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo timed in us, converted to cm by counting.
// Latency: echo pin fall -> IO_Sonar/sample_stb in 3 HCLK. Backpressure: none, sample_stb is a strobe.
module mfp_sonar_ranger
  import mfp_sonar_ranger_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000,
  parameter int US_PER_CM  = 58
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] IO_Sonar,
  output logic        sample_stb,
  output logic        busy
);

  localparam int US_DIV = CLK_HZ / 1_000_000;
  localparam int PW = cnt_w(US_DIV - 1);
  localparam int UW = cnt_w((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US);
  localparam int RW = cnt_w(PERIOD_US);
  localparam int SW = cnt_w(US_PER_CM - 1);

  localparam logic [PW-1:0] PRESC_MAX   = PW'(US_DIV - 1);
  localparam logic [UW-1:0] TRIG_END    = UW'(TRIG_US);
  localparam logic [UW-1:0] TIMEOUT_END = UW'(TIMEOUT_US);
  localparam logic [RW-1:0] PERIOD_END  = RW'(PERIOD_US);
  localparam logic [SW-1:0] SUB_MAX     = SW'(US_PER_CM - 1);

  sonar_state_e   state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [UW-1:0]  us_q, us_d, us_inc;
  logic [RW-1:0]  per_q, per_d, per_inc;
  logic [SW-1:0]  sub_q, sub_d, sub_nxt;
  logic [15:0]    cm_q, cm_d, cm_nxt;
  logic [15:0]    sonar_q, sonar_d;
  logic           stb_q, stb_d;
  logic           trig_q, trig_d;
  logic           busy_q, busy_d;
  logic           echo_dly_q, echo_dly_d;
  logic           echo_s, rise, fall, tick;

  mfp_sync2 #(.WIDTH(1)) u_echo_sync (
    .clk (HCLK),
    .rst (HRESET),
    .d   (echo),
    .q   (echo_s)
  );

  assign rise    = echo_s & ~echo_dly_q;
  assign fall    = ~echo_s & echo_dly_q;
  assign tick    = (presc_q == PRESC_MAX);
  assign us_inc  = us_q + UW'(tick);
  assign per_inc = per_q + RW'(tick);

  always_comb begin
    sub_nxt = sub_q;
    cm_nxt  = cm_q;
    if (tick) begin
      if (sub_q == SUB_MAX) begin
        sub_nxt = '0;
        if (cm_q != SONAR_CM_SAT) cm_nxt = cm_q + 16'd1;
      end else begin
        sub_nxt = sub_q + SW'(1);
      end
    end
  end

  // Timeouts and the period end fire on the tick that reaches the limit, so
  // an idle-echo cycle spans exactly PERIOD_US us from trigger to IDLE.
  always_comb begin
    state_d    = state_q;
    presc_d    = tick ? '0 : presc_q + PW'(1);
    us_d       = us_q;
    per_d      = per_q;
    sub_d      = sub_q;
    cm_d       = cm_q;
    sonar_d    = sonar_q;
    stb_d      = 1'b0;
    echo_dly_d = echo_s;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_TRIG;
          per_d   = '0;
          us_d    = '0;
        end
      end
      ST_TRIG: begin
        per_d = per_inc;
        us_d  = us_inc;
        if (us_inc == TRIG_END) begin
          state_d = ST_WAIT_RISE;
          us_d    = '0;
        end
      end
      ST_WAIT_RISE: begin
        per_d = per_inc;
        us_d  = us_inc;
        if (rise) begin
          state_d = ST_MEASURE;
          us_d    = '0;
          cm_d    = '0;
          sub_d   = '0;
        end else if (us_inc == TIMEOUT_END) begin
          state_d = ST_HOLD;
          sonar_d = SONAR_TIMEOUT_CODE;
          stb_d   = 1'b1;
        end
      end
      ST_MEASURE: begin
        per_d = per_inc;
        us_d  = us_inc;
        sub_d = sub_nxt;
        cm_d  = cm_nxt;
        if (fall) begin
          state_d = ST_HOLD;
          sonar_d = cm_nxt;
          stb_d   = 1'b1;
        end else if (us_inc == TIMEOUT_END) begin
          state_d = ST_HOLD;
          sonar_d = SONAR_TIMEOUT_CODE;
          stb_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        per_d = per_inc;
        if (per_inc == PERIOD_END) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) presc_d = '0;
    trig_d = (state_d == ST_TRIG);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      us_q       <= '0;
      per_q      <= '0;
      sub_q      <= '0;
      cm_q       <= '0;
      sonar_q    <= '0;
      stb_q      <= 1'b0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      echo_dly_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      us_q       <= us_d;
      per_q      <= per_d;
      sub_q      <= sub_d;
      cm_q       <= cm_d;
      sonar_q    <= sonar_d;
      stb_q      <= stb_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      echo_dly_q <= echo_dly_d;
    end
  end

  assign trig       = trig_q;
  assign IO_Sonar   = sonar_q;
  assign sample_stb = stb_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mfp_sonar_ranger.sv
// Bench for mfp_sonar_ranger with scaled-down timing; expected ranges come from
// echo width arithmetic (cycles -> us -> cm) and the published timing rules.
module tb_mfp_sonar_ranger;

  localparam int CLK_HZ     = 4_000_000;
  localparam int TRIG_US    = 3;
  localparam int TIMEOUT_US = 50;
  localparam int PERIOD_US  = 130;
  localparam int US_PER_CM  = 5;
  localparam int D          = CLK_HZ / 1_000_000;
  localparam int TD         = TIMEOUT_US * D;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        enable = 1'b0;
  logic        echo = 1'b0;
  logic        trig;
  logic [15:0] IO_Sonar;
  logic        sample_stb;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mfp_sonar_ranger #(
    .CLK_HZ     (CLK_HZ),
    .TRIG_US    (TRIG_US),
    .TIMEOUT_US (TIMEOUT_US),
    .PERIOD_US  (PERIOD_US),
    .US_PER_CM  (US_PER_CM)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .enable     (enable),
    .echo       (echo),
    .trig       (trig),
    .IO_Sonar   (IO_Sonar),
    .sample_stb (sample_stb),
    .busy       (busy)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // Counts negedges until trig equals lvl; an expired budget is a miscompare.
  task automatic wait_trig(input logic lvl, input int budget, output int n);
    n = 0;
    while (trig !== lvl && n < budget) begin
      @(negedge HCLK);
      n++;
    end
    chk("trig_wait", {31'b0, trig === lvl}, 32'd1);
  endtask

  // Reference: pin high w cycles -> floor(w/D) us -> floor(us/US_PER_CM) cm,
  // valid up to TIMEOUT_US, published 3 cycles after the pin falls; longer
  // echoes give the timeout code TIMEOUT_US us after the synced rise.
  task automatic run_echo(input int dly, input int w, input bit pre_high, input bit drop_en);
    int n, first_k, n_stb, exp_k, exp_v, lim;
    logic [15:0] val;
    wait_trig(1'b1, 2 * PERIOD_US * D + 50, n);
    if (pre_high) begin
      tick_n(2);
      echo = 1'b1;
    end
    wait_trig(1'b0, TRIG_US * D + 5, n);
    if (pre_high) begin
      tick_n(20);
      echo = 1'b0;
    end
    tick_n(dly);
    echo  = 1'b1;
    exp_k = (w <= TD) ? w + 3 : TD + 3;
    exp_v = (w <= TD) ? (w / D) / US_PER_CM : 32'hFFFF;
    lim   = ((w > exp_k) ? w : exp_k) + 5;
    first_k = -1;
    n_stb   = 0;
    val     = '0;
    for (int i = 1; i <= lim; i++) begin
      @(negedge HCLK);
      if (sample_stb === 1'b1) begin
        n_stb++;
        if (first_k < 0) begin
          first_k = i;
          val     = IO_Sonar;
        end
      end
      if (i == w) echo = 1'b0;
      if (drop_en && i == 2) enable = 1'b0;
    end
    chk("stb_latency", first_k, exp_k);
    chk("stb_count", n_stb, 1);
    chk("range_cm", {16'b0, val}, exp_v);
  endtask

  initial begin
    int n, seen, w_list[8], d_list[8];

    tick_n(3);
    chk("rst_trig", {31'b0, trig}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_sonar", {16'b0, IO_Sonar}, 0);
    chk("rst_stb", {31'b0, sample_stb}, 0);
    HRESET = 1'b0;
    tick_n(4);
    chk("idle_busy", {31'b0, busy}, 0);

    // No echo: trig width, timeout publish, and trigger-to-trigger period.
    enable = 1'b1;
    wait_trig(1'b1, 10, n);
    chk("busy_on", {31'b0, busy}, 1);
    wait_trig(1'b0, TRIG_US * D + 20, n);
    chk("trig_width", n, TRIG_US * D);
    seen = 0;
    n = 0;
    while (sample_stb !== 1'b1 && n < TD + 20) begin
      @(negedge HCLK);
      n++;
    end
    chk("tmo_delay", n, TD);
    chk("tmo_code", {16'b0, IO_Sonar}, 32'hFFFF);
    tick_n(1);
    chk("stb_1cyc", {31'b0, sample_stb}, 0);
    wait_trig(1'b1, 2 * PERIOD_US * D, seen);
    chk("period", TRIG_US * D + TD + 1 + seen, PERIOD_US * D + 1);
    chk("sonar_hold", {16'b0, IO_Sonar}, 32'hFFFF);

    // Synchronous reset mid-MEASURE.
    wait_trig(1'b0, TRIG_US * D + 5, n);
    tick_n(5);
    echo = 1'b1;
    tick_n(30);
    HRESET = 1'b1;
    tick_n(1);
    HRESET = 1'b0;
    chk("mid_rst_trig", {31'b0, trig}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_sonar", {16'b0, IO_Sonar}, 0);
    chk("mid_rst_stb", {31'b0, sample_stb}, 0);
    echo = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      if (sample_stb === 1'b1) seen++;
    end
    chk("rst_no_stb", seen, 0);

    // Directed widths around cm and timeout boundaries.
    w_list = '{200, 201, 16, 19, 76, 80, 4, 260};
    d_list = '{0, 7, 30, 1, 60, 13, 2, 9};
    foreach (w_list[i]) run_echo(d_list[i], w_list[i], 1'b0, 1'b0);

    // Echo already high when WAIT_RISE is entered.
    run_echo(20, 60, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++)
      run_echo(int'($urandom_range(0, 60)), int'($urandom_range(1, TD + 10)), 1'b0, 1'b0);

    // Dropping enable mid-measurement still publishes, then stops triggering.
    run_echo(5, 120, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 2 * PERIOD_US * D; i++) begin
      @(negedge HCLK);
      if (trig === 1'b1) seen++;
    end
    chk("no_retrig", seen, 0);
    chk("idle_after", {31'b0, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
